dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage (upstream) and the block data memory (downstream).
- Serves 32-bit word loads and stores from a local line array.
- On a miss, writes back a dirty victim block and then refills the line using the memory's level-sensitive block read/write strobes.
- On halt, walks every line, writes back all dirty blocks, then raises the memory dump/finish strobe.

---
 rtl/dcache_ctrl.sv | 119 +++++++++++
 tb/tb_dcache_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller with halt-time flush
module dcache_ctrl #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int LINES   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [WORD_W-1:0]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_rdata,
  input  logic               halt,
  output logic [WORD_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               mem_flush
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_W - 4 - IDX_W;
  localparam int NW    = BLOCK_W / WORD_W;
  localparam int CW    = $clog2(MEM_LAT + 2);
  localparam logic [CW-1:0] LAT    = CW'(MEM_LAT);
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RD, FL_SCAN, FL_WB, DONE} state_t;
  state_t              r_state, w_next;
  logic [LINES-1:0]    r_valid, r_dirty;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [BLOCK_W-1:0]  r_data [LINES];
  logic [WORD_W-1:0]   r_addr, r_wdata, r_rdata;
  logic                r_we, r_resp_valid;
  logic [CW-1:0]       r_cnt;
  logic [IDX_W-1:0]    r_line;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_sel;
  int                  w_off;
  logic                w_hit, w_store, w_fill, w_xfer_end, w_line_dirty, w_unused;
  assign w_idx        = r_addr[4 +: IDX_W];
  assign w_tag        = r_addr[WORD_W-1 -: TAG_W];
  assign w_sel        = r_addr[3:2];
  assign w_off        = WORD_W * (NW - 1 - int'(w_sel));
  assign w_hit        = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_store      = r_state == LOOKUP && w_hit && r_we;
  assign w_fill       = r_state == RD && r_cnt == LAT_M1;
  assign w_xfer_end   = r_cnt == LAT;
  assign w_line_dirty = r_valid[r_line] && r_dirty[r_line];
  assign w_unused     = ^r_addr[1:0];
  assign req_ready    = r_state == IDLE;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_rdata;
  assign mem_flush    = r_state == DONE;
  assign mem_read     = r_state == RD && r_cnt < LAT;
  assign mem_write    = (r_state == WB || r_state == FL_WB) && r_cnt < LAT;
  assign mem_addr     = r_state == RD    ? {w_tag, w_idx, 4'h0} :
                        r_state == WB    ? {r_tag[w_idx], w_idx, 4'h0} :
                        r_state == FL_WB ? {r_tag[r_line], r_line, 4'h0} : '0;
  assign mem_wdata    = r_state == WB    ? r_data[w_idx] :
                        r_state == FL_WB ? r_data[r_line] : '0;
  // next-state: every transfer ends with one strobe-low cycle before leaving its state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = halt ? FL_SCAN : req_valid ? LOOKUP : IDLE;
      LOOKUP:  w_next = w_hit ? IDLE : (r_valid[w_idx] && r_dirty[w_idx]) ? WB : RD;
      WB:      w_next = w_xfer_end ? RD : WB;
      RD:      w_next = w_xfer_end ? LOOKUP : RD;
      FL_SCAN: w_next = w_line_dirty ? FL_WB : (&r_line) ? DONE : FL_SCAN;
      FL_WB:   w_next = w_xfer_end ? FL_SCAN : FL_WB;
      default: w_next = r_state;
    endcase
  end
  // control state, transfer counter, flush counter, request latch, response and line status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_valid      <= '0;
      r_dirty      <= '0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_next != r_state ? '0 : r_cnt + 1'b1;
      r_resp_valid <= r_state == LOOKUP && w_hit;
      if (r_state == IDLE && halt) r_line <= '0;
      else if (r_state == FL_SCAN && !w_line_dirty) r_line <= r_line + 1'b1;
      if (r_state == IDLE && req_valid && !halt) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
      end
      if (r_state == LOOKUP && w_hit && !r_we) r_rdata <= r_data[w_idx][w_off +: WORD_W];
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_store) r_dirty[w_idx] <= 1'b1;
      if (r_state == FL_WB && w_xfer_end) r_dirty[r_line] <= 1'b0;
    end
  end
  // tag and data arrays: refill installs a block, store hit merges one word
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_store) r_data[w_idx][w_off +: WORD_W] <= r_wdata;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized self-checking bench against a flat-memory and tag-directory model
module tb_dcache_ctrl;
  localparam int LAT = 2;
  typedef struct packed {logic w; logic [31:0] a; logic [127:0] d; logic [7:0] l;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, halt = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, mem_read, mem_write, mem_flush;
  logic [31:0] resp_rdata, mem_addr;
  logic [127:0] mem_wdata, mem_rdata = '0;
  int checks = 0, failures = 0;
  int overlap_err = 0, gap_err = 0, stab_err = 0;
  ev_t ev_q[$];
  logic [127:0] mem [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  bit m_valid [16], m_dirty [16];
  logic [23:0] m_tag [16];
  logic [23:0] tg [4] = '{24'h000000, 24'h000001, 24'h0003C5, 24'hFFFFF0};
  dcache_ctrl #(.WORD_W(32), .BLOCK_W(128), .LINES(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .halt(halt), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_flush(mem_flush));
  always #5 clk = ~clk;
  function automatic logic [127:0] init_blk(input logic [31:0] a);
    if (a == 32'h40) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
    return {a * 32'h9E3779B1, ~a, a ^ 32'h5A5A5A5A, a + 32'h01234567};
  endfunction
  function automatic logic [127:0] mem_blk(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_blk(a);
  endfunction
  // CPU-visible word: last store if any, otherwise what the backing memory holds
  function automatic logic [31:0] gword(input logic [31:0] a);
    logic [31:0] k;
    logic [127:0] b;
    k = {a[31:2], 2'b00};
    if (gold.exists(k)) return gold[k];
    b = mem_blk({a[31:4], 4'h0});
    return b[127 - 32 * int'(a[3:2]) -: 32];
  endfunction
  function automatic logic [127:0] gblk(input logic [31:0] b);
    return {gword(b), gword(b + 4), gword(b + 8), gword(b + 12)};
  endfunction
  // memory responder and strobe-window recorder
  logic prv_r = 1'b0, prv_w = 1'b0, wk = 1'b0;
  logic [31:0] wa = '0;
  logic [127:0] wd = '0;
  logic [7:0] wl = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prv_r = 1'b0;
      prv_w = 1'b0;
      mem_rdata = '0;
    end else begin
      if (mem_read && mem_write) overlap_err++;
      if ((prv_r && !mem_read) || (prv_w && !mem_write)) begin
        ev_q.push_back('{wk, wa, wd, wl});
        if (wk) mem[wa] = wd;
      end
      if ((mem_read && !prv_r) || (mem_write && !prv_w)) begin
        if (prv_r || prv_w) gap_err++;
        wk = mem_write; wa = mem_addr; wd = mem_wdata; wl = 8'd1;
      end else if (mem_read || mem_write) begin
        wl++;
        if (mem_addr !== wa || (wk && mem_wdata !== wd)) stab_err++;
      end
      mem_rdata = mem_read ? mem_blk(mem_addr) : {$urandom(), $urandom(), $urandom(), $urandom()};
      prv_r = mem_read;
      prv_w = mem_write;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    halt = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_read, mem_write, mem_flush} !== 5'b10000) begin
      failures++;
      $display("FAIL %s reset_ctrl got rdy/rv/rd/wr/fl=%b want 10000", nm,
               {req_ready, resp_valid, mem_read, mem_write, mem_flush});
    end
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0 || resp_rdata !== 0) begin
      failures++;
      $display("FAIL %s reset_data got addr=%h wdata=%h rdata=%h want zeros", nm, mem_addr, mem_wdata, resp_rdata);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    foreach (m_valid[i]) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    gold.delete();
    ev_q.delete();
    overlap_err = 0; gap_err = 0; stab_err = 0;
  endtask
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wdat, input string nm);
    ev_t exp_q[$];
    int i, n;
    logic [23:0] t;
    bit hit;
    logic [31:0] exp_rd, vb;
    i = int'(a[7:4]);
    t = a[31:8];
    hit = m_valid[i] && m_tag[i] == t;
    exp_rd = gword(a);
    if (!hit) begin
      if (m_valid[i] && m_dirty[i]) begin
        vb = {m_tag[i], a[7:4], 4'h0};
        exp_q.push_back('{1'b1, vb, gblk(vb), 8'(LAT)});
      end
      exp_q.push_back('{1'b0, {t, a[7:4], 4'h0}, 128'h0, 8'(LAT)});
    end
    ev_q.delete();
    overlap_err = 0; gap_err = 0; stab_err = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL %s ready got %b want 1", nm, req_ready); end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wdat;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_we = ~we; req_addr = $urandom(); req_wdata = $urandom();
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 100);
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL %s resp_timeout got none want resp_valid", nm); end
    if (hit) begin
      checks++;
      if (n != 2) begin failures++; $display("FAIL %s hit_latency got %0d want 2", nm, n); end
    end
    if (!we) begin
      checks++;
      if (resp_rdata !== exp_rd) begin failures++; $display("FAIL %s rdata got %h want %h", nm, resp_rdata, exp_rd); end
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL %s resp_pulse got %b want 0", nm, resp_valid); end
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s mem_xfers got %0d want %0d", nm, ev_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < ev_q.size()) begin
      checks++;
      if (ev_q[k].w !== exp_q[k].w || ev_q[k].a !== exp_q[k].a || ev_q[k].l !== exp_q[k].l ||
          (exp_q[k].w && ev_q[k].d !== exp_q[k].d)) begin
        failures++;
        $display("FAIL %s xfer%0d got w=%b a=%h len=%0d d=%h want w=%b a=%h len=%0d d=%h", nm, k,
                 ev_q[k].w, ev_q[k].a, ev_q[k].l, ev_q[k].d, exp_q[k].w, exp_q[k].a, exp_q[k].l, exp_q[k].d);
      end
    end
    checks++;
    if (overlap_err + gap_err + stab_err != 0) begin
      failures++;
      $display("FAIL %s strobe_rules got overlap=%0d gap=%0d unstable=%0d want 0", nm, overlap_err, gap_err, stab_err);
    end
    if (!hit) begin m_valid[i] = 1; m_tag[i] = t; m_dirty[i] = 0; end
    if (we) begin gold[{a[31:2], 2'b00}] = wdat; m_dirty[i] = 1; end
  endtask
  task automatic do_flush(input bit with_req, input string nm);
    ev_t exp_q[$];
    int n;
    bit resp_seen, hold_ok;
    logic [31:0] vb;
    for (int i = 0; i < 16; i++) if (m_valid[i] && m_dirty[i]) begin
      vb = {m_tag[i], 4'(i), 4'h0};
      exp_q.push_back('{1'b1, vb, gblk(vb), 8'(LAT)});
    end
    ev_q.delete();
    overlap_err = 0; gap_err = 0; stab_err = 0;
    @(negedge clk);
    halt = 1'b1;
    if (with_req) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2C4; req_wdata = 32'hBAD0BAD0; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; resp_seen = 0;
    do begin @(negedge clk); n++; if (resp_valid) resp_seen = 1; end while (!mem_flush && n < 1000);
    checks++;
    if (mem_flush !== 1'b1) begin failures++; $display("FAIL %s flush_timeout got mem_flush=%b want 1", nm, mem_flush); end
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s flush_writes got %0d want %0d", nm, ev_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < ev_q.size()) begin
      checks++;
      if (ev_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL %s flush_xfer%0d got w=%b a=%h len=%0d d=%h want w=1 a=%h len=%0d d=%h", nm, k,
                 ev_q[k].w, ev_q[k].a, ev_q[k].l, ev_q[k].d, exp_q[k].a, exp_q[k].l, exp_q[k].d);
      end
    end
    checks++;
    if (overlap_err + gap_err + stab_err != 0) begin
      failures++;
      $display("FAIL %s flush_strobes got overlap=%0d gap=%0d unstable=%0d want 0", nm, overlap_err, gap_err, stab_err);
    end
    hold_ok = 1;
    req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_flush !== 1'b1 || req_ready !== 1'b0 || resp_valid) begin resp_seen |= resp_valid; hold_ok = 0; end
      if (mem_read || mem_write) hold_ok = 0;
    end
    req_valid = 1'b0; halt = 1'b0;
    checks++;
    if (!hold_ok) begin failures++; $display("FAIL %s done_hold got flush=%b ready=%b want flush=1 ready=0", nm, mem_flush, req_ready); end
    checks++;
    if (resp_seen) begin failures++; $display("FAIL %s no_resp got resp_valid=1 want none during flush", nm); end
  endtask
  task automatic test_reset();
    do_reset("reset");
  endtask
  task automatic test_cold_load();
    access(0, 32'h40, 32'h0, "cold_load");
    checks++;
    if (resp_rdata !== 32'h00112233) begin failures++; $display("FAIL cold_word got %h want 00112233", resp_rdata); end
    access(0, 32'h48, 32'h0, "repeat_load");
    checks++;
    if (resp_rdata !== 32'h8899AABB) begin failures++; $display("FAIL repeat_word got %h want 8899aabb", resp_rdata); end
  endtask
  task automatic test_evict();
    access(1, 32'h44, 32'hDEADBEEF, "store_hit");
    access(0, 32'h140, 32'h0, "dirty_evict");
    checks++;
    if (ev_q.size() != 2 || !ev_q[0].w || ev_q[0].a !== 32'h40 || ev_q[0].d[95:64] !== 32'hDEADBEEF || ev_q[1].w || ev_q[1].a !== 32'h140)
      begin failures++; $display("FAIL evict_order got n=%0d first_a=%h want write 40 word1 deadbeef then read 140", ev_q.size(), ev_q.size() > 0 ? ev_q[0].a : 32'h0); end
  endtask
  task automatic test_store_miss();
    access(1, 32'h80, 32'hCAFEF00D, "store_miss");
    access(0, 32'h80, 32'h0, "load_after_store");
    checks++;
    if (resp_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL store_miss_word got %h want cafef00d", resp_rdata); end
  endtask
  task automatic test_flush();
    @(negedge clk);
    do_reset("flush_reset");
    access(1, 32'h000, $urandom(), "dirty_idx0");
    access(1, 32'h0F0, $urandom(), "dirty_idx15");
    do_flush(0, "flush");
    checks++;
    if (ev_q.size() != 2 || ev_q[0].a !== 32'h000 || ev_q[1].a !== 32'h0F0)
      begin failures++; $display("FAIL flush_index_order got n=%0d want writes at 0 then f0", ev_q.size()); end
  endtask
  task automatic test_halt_priority();
    @(negedge clk);
    do_reset("halt_reset");
    access(1, 32'h2C4, 32'h13572468, "pre_halt_store");
    do_flush(1, "halt_with_req");
  endtask
  task automatic test_reset_mid_refill();
    int n;
    @(negedge clk);
    do_reset("mid_reset_pre");
    access(0, 32'h40, 32'h0, "mid_fill");
    access(0, 32'h40, 32'h0, "mid_hit");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_read && n < 20);
    checks++;
    if (mem_read !== 1'b1) begin failures++; $display("FAIL mid_refill_start got mem_read=%b want 1", mem_read); end
    do_reset("mid_refill");
    access(0, 32'h40, 32'h0, "after_reset");
    checks++;
    if (ev_q.size() != 1 || ev_q[0].w || ev_q[0].a !== 32'h40)
      begin failures++; $display("FAIL after_reset_miss got n=%0d want one read at 40", ev_q.size()); end
  endtask
  task automatic test_random();
    logic [31:0] a;
    logic [127:0] b;
    @(negedge clk);
    do_reset("rand_reset");
    for (int k = 0; k < 300; k++) begin
      a = {tg[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom(), "random");
    end
    do_flush(0, "rand_flush");
    foreach (gold[k]) begin
      b = mem_blk({k[31:4], 4'h0});
      checks++;
      if (b[127 - 32 * int'(k[3:2]) -: 32] !== gold[k]) begin
        failures++;
        $display("FAIL rand_mem_image addr=%h got %h want %h", k, b[127 - 32 * int'(k[3:2]) -: 32], gold[k]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_cold_load();
    test_evict();
    test_store_miss();
    test_flush();
    test_halt_priority();
    test_reset_mid_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
